// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared definitions for the Wishbone master bridge.
//               - Transfer-width encodings used on the host and bus sides.
//               - Bridge FSM state encoding.
//               - wb_width_mask(): byte-lane mask for a transfer width.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam logic [1:0] WB_W8   = 2'b00;
    localparam logic [1:0] WB_W16  = 2'b01;
    localparam logic [1:0] WB_W32  = 2'b10;
    localparam logic [1:0] WB_WRSV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_RESP     = 3'd4
    } wb_state_e;

    // Read-data mask for a transfer width. The reserved width yields 0, so
    // nothing from the bus can leak into an error response.
    function automatic logic [31:0] wb_width_mask(input logic [1:0] width);
        logic [31:0] mask;
        case (width)
            WB_W8:   mask = 32'h0000_00FF;
            WB_W16:  mask = 32'h0000_FFFF;
            WB_W32:  mask = 32'hFFFF_FFFF;
            default: mask = 32'h0000_0000;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : wb_watchdog
// Description : 8-bit cycle counter that flags a bus cycle as abandoned.
//               The count is cleared by i_clear and advances each cycle
//               i_enable is high. o_expired is asserted while the count
//               equals TIMEOUT-1.
// Ports       : clk, reset_n   - clock, async active-low reset
//               i_clear        - synchronous clear (priority over enable)
//               i_enable       - count this cycle
//               o_expired      - count has reached TIMEOUT-1
// Revision    : 1.0 - initial release
// ============================================================================
module wb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [7:0] C_LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] r_count;
    logic       w_expired;

    assign w_expired = (r_count == C_LIMIT);
    assign o_expired = w_expired;

    // The count holds at the limit so it can never wrap back to a value
    // that would hide an expiry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable && !w_expired) begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : wb_master_bridge
// Description : Converts single host requests (valid/ready) into one
//               pipelined Wishbone transaction each, masks read data to the
//               requested width and abandons cycles that are never acked.
// Ports       : clk, reset_n                 - clock, async active-low reset
//               i_req_valid / o_req_ready    - host request handshake
//               i_req_we/width/addr/data     - host request fields
//               o_rsp_valid/err/data         - one-cycle host response
//               o_wb_cyc/stb/we/width/addr/data, i_wb_stl/ack/data
//                                            - Wishbone initiator port
// Revision    : 1.0 - initial release
// ============================================================================
module wb_master_bridge
    import wb_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [1:0]        i_req_width,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_data,
    output logic              o_rsp_valid,
    output logic              o_rsp_err,
    output logic [31:0]       o_rsp_data,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    input  logic              i_wb_stl,
    input  logic              i_wb_ack,
    output logic              o_wb_we,
    output logic [1:0]        o_wb_width,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic [31:0]       o_wb_data,
    input  logic [31:0]       i_wb_data
);

    wb_state_e         r_state;
    wb_state_e         w_state_nxt;

    logic              r_wb_we;
    logic [1:0]        r_wb_width;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [31:0]       r_wb_data;
    logic              r_err;
    logic [31:0]       r_rsp_data;

    logic              w_accept;
    logic              w_rsv;
    logic              w_acked;
    logic              w_expired;
    logic              w_timeout;
    logic              w_cyc;
    logic              w_stb;
    logic              w_rsp;
    logic              w_ready;

    assign w_accept = (r_state == ST_IDLE) && i_req_valid;
    assign w_rsv    = (i_req_width == WB_WRSV);

    // An ack only counts in REQ if the strobe is accepted that same cycle;
    // an ack that arrives while stalled is ignored.
    assign w_acked  = ((r_state == ST_REQ) && !i_wb_stl && i_wb_ack) ||
                      ((r_state == ST_WAIT_ACK) && i_wb_ack);

    // A same-cycle ack wins over the watchdog.
    assign w_timeout = ((r_state == ST_REQ) || (r_state == ST_WAIT_ACK)) &&
                       w_expired && !w_acked;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_cyc       = 1'b0;
        w_stb       = 1'b0;
        w_rsp       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (i_req_valid) begin
                    w_state_nxt = w_rsv ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                w_cyc = 1'b1;
                w_stb = 1'b1;
                if (w_acked) begin
                    w_state_nxt = r_wb_we ? ST_RESP : ST_CAPTURE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_RESP;
                end else if (!i_wb_stl) begin
                    w_state_nxt = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                w_cyc = 1'b1;
                if (w_acked) begin
                    w_state_nxt = r_wb_we ? ST_RESP : ST_CAPTURE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_CAPTURE: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_rsp       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request / response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wb_we    <= 1'b0;
            r_wb_width <= 2'b00;
            r_wb_addr  <= '0;
            r_wb_data  <= 32'd0;
            r_err      <= 1'b0;
            r_rsp_data <= 32'd0;
        end else begin
            if (w_accept) begin
                r_err      <= w_rsv;
                r_rsp_data <= 32'd0;
                // A reserved width never reaches the bus, so the bus-side
                // fields keep their previous values.
                if (!w_rsv) begin
                    r_wb_we    <= i_req_we;
                    r_wb_width <= i_req_width;
                    r_wb_addr  <= i_req_addr;
                    r_wb_data  <= i_req_data;
                end
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            // Registered-read slaves present data the cycle after the ack.
            if (r_state == ST_CAPTURE) begin
                r_rsp_data <= i_wb_data & wb_width_mask(r_wb_width);
            end
        end
    end

    // ------------------------------------------------------------------
    // Watchdog: cleared while idle, counts every cycle the bus is owned
    // ------------------------------------------------------------------
    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (r_state == ST_IDLE),
        .i_enable  (w_cyc),
        .o_expired (w_expired)
    );

    assign o_req_ready = w_ready;
    assign o_wb_cyc    = w_cyc;
    assign o_wb_stb    = w_stb;
    assign o_wb_we     = r_wb_we;
    assign o_wb_width  = r_wb_width;
    assign o_wb_addr   = r_wb_addr;
    assign o_wb_data   = r_wb_data;
    assign o_rsp_valid = w_rsp;
    assign o_rsp_err   = w_rsp & r_err;
    assign o_rsp_data  = w_rsp ? r_rsp_data : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_master_bridge
// Description : Directed self-checking bench for wb_master_bridge with a
//               behavioural byte-addressed slave (zero-wait, stalled,
//               delayed-ack and never-ack modes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_master_bridge;

    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              i_req_valid = 1'b0;
    logic              o_req_ready;
    logic              i_req_we = 1'b0;
    logic [1:0]        i_req_width = 2'b00;
    logic [ADDR_W-1:0] i_req_addr = '0;
    logic [31:0]       i_req_data = 32'd0;
    logic              o_rsp_valid;
    logic              o_rsp_err;
    logic [31:0]       o_rsp_data;
    logic              o_wb_cyc;
    logic              o_wb_stb;
    logic              i_wb_stl = 1'b0;
    logic              i_wb_ack = 1'b0;
    logic              o_wb_we;
    logic [1:0]        o_wb_width;
    logic [ADDR_W-1:0] o_wb_addr;
    logic [31:0]       o_wb_data;
    logic [31:0]       i_wb_data = 32'd0;

    wb_master_bridge #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_we    (i_req_we),
        .i_req_width (i_req_width),
        .i_req_addr  (i_req_addr),
        .i_req_data  (i_req_data),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_err   (o_rsp_err),
        .o_rsp_data  (o_rsp_data),
        .o_wb_cyc    (o_wb_cyc),
        .o_wb_stb    (o_wb_stb),
        .i_wb_stl    (i_wb_stl),
        .i_wb_ack    (i_wb_ack),
        .o_wb_we     (o_wb_we),
        .o_wb_width  (o_wb_width),
        .o_wb_addr   (o_wb_addr),
        .o_wb_data   (o_wb_data),
        .i_wb_data   (i_wb_data)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural slave: 0 = zero-wait, 1 = never ack, 2 = ack 2 cycles
    // after strobe accept. stall_left stalls the strobe that many cycles.
    // ------------------------------------------------------------------
    logic [7:0]        mem [64];
    int                mode = 0;
    int                stall_left = 0;
    int                wait_left = 0;
    logic              rd_pend = 1'b0;
    logic [ADDR_W-1:0] s_addr;
    logic              s_we;
    logic [1:0]        s_width;
    logic [31:0]       s_data;

    function automatic logic [31:0] mem_rd(input logic [ADDR_W-1:0] a);
        return {mem[a + 6'd3], mem[a + 6'd2], mem[a + 6'd1], mem[a]};
    endfunction

    task automatic slave_ack();
        int n;
        i_wb_ack = 1'b1;
        if (s_we) begin
            n = (s_width == 2'b00) ? 1 : (s_width == 2'b01) ? 2 : 4;
            for (int i = 0; i < n; i++) mem[s_addr + 6'(i)] = s_data[8*i +: 8];
        end else begin
            rd_pend = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        i_wb_stl  = 1'b0;
        i_wb_ack  = 1'b0;
        i_wb_data = 32'hCAFE_F00D;
        if (rd_pend) begin
            i_wb_data = mem_rd(s_addr);
            rd_pend   = 1'b0;
        end
        if (o_wb_stb) begin
            if (stall_left > 0) begin
                i_wb_stl = 1'b1;
                stall_left--;
            end else begin
                s_addr  = o_wb_addr;
                s_we    = o_wb_we;
                s_width = o_wb_width;
                s_data  = o_wb_data;
                if (mode == 0) slave_ack();
                else if (mode == 2) wait_left = 2;
            end
        end else if (o_wb_cyc && wait_left > 0) begin
            wait_left--;
            if (wait_left == 0) slave_ack();
        end
    end

    // ------------------------------------------------------------------
    // One host request; latency counted from the handshake cycle (= 0).
    // ------------------------------------------------------------------
    task automatic do_req(input logic we, input logic [1:0] w, input logic [ADDR_W-1:0] a,
                          input logic [31:0] d, output int lat, output int ncyc, output int nstb,
                          output int nunst, output logic err, output logic [31:0] rdata);
        int guard;
        lat = -1; ncyc = 0; nstb = 0; nunst = 0; err = 1'b0; rdata = 32'd0;
        @(negedge clk);
        guard = 0;
        while (!o_req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_width = w;
        i_req_addr  = a;
        i_req_data  = d;
        @(posedge clk);
        #1 i_req_valid = 1'b0;
        for (int c = 1; c <= 64 && lat < 0; c++) begin
            @(negedge clk);
            if (o_wb_cyc) begin
                ncyc++;
                if (o_wb_addr !== a || o_wb_we !== we || o_wb_width !== w ||
                    (we && o_wb_data !== d)) nunst++;
            end
            if (o_wb_stb) nstb++;
            if (o_rsp_valid) begin
                lat   = c;
                err   = o_rsp_err;
                rdata = o_rsp_data;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int lat, ncyc, nstb, nunst;
        logic err;
        logic [31:0] rd;

        for (int i = 0; i < 64; i++) mem[i] = 8'h5A;

        // Reset state
        #12;
        chk("rst_ready", 32'(o_req_ready), 32'd1);
        chk("rst_cyc",   32'(o_wb_cyc),    32'd0);
        chk("rst_stb",   32'(o_wb_stb),    32'd0);
        chk("rst_rsp",   32'(o_rsp_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Zero-wait write then reads
        mode = 0;
        do_req(1'b1, 2'b10, 6'h04, 32'hDEAD_BEEF, lat, ncyc, nstb, nunst, err, rd);
        chk("wr_lat", 32'(lat), 32'd2);
        chk("wr_err", 32'(err), 32'd0);
        chk("wr_data0", rd, 32'd0);
        do_req(1'b0, 2'b10, 6'h04, 32'd0, lat, ncyc, nstb, nunst, err, rd);
        chk("rd32_lat",  32'(lat), 32'd3);
        chk("rd32_data", rd, 32'hDEAD_BEEF);
        chk("rd32_err",  32'(err), 32'd0);
        do_req(1'b0, 2'b00, 6'h05, 32'd0, lat, ncyc, nstb, nunst, err, rd);
        chk("rd8_data", rd, 32'h0000_00BE);
        do_req(1'b0, 2'b01, 6'h04, 32'd0, lat, ncyc, nstb, nunst, err, rd);
        chk("rd16_data", rd, 32'h0000_BEEF);

        // Stalled write: strobe held 4 cycles, response 3 cycles late
        stall_left = 3;
        do_req(1'b1, 2'b01, 6'h10, 32'h0000_1234, lat, ncyc, nstb, nunst, err, rd);
        chk("stl_nstb",  32'(nstb),  32'd4);
        chk("stl_lat",   32'(lat),   32'd5);
        chk("stl_stable", 32'(nunst), 32'd0);
        do_req(1'b0, 2'b01, 6'h10, 32'd0, lat, ncyc, nstb, nunst, err, rd);
        chk("stl_rdback", rd, 32'h0000_1234);

        // Delayed ack: two extra cycles in WAIT_ACK
        mode = 2;
        do_req(1'b0, 2'b10, 6'h04, 32'd0, lat, ncyc, nstb, nunst, err, rd);
        chk("wait_lat",  32'(lat), 32'd5);
        chk("wait_data", rd, 32'hDEAD_BEEF);

        // Never-acking slave: watchdog abandons the cycle
        mode = 1;
        do_req(1'b0, 2'b10, 6'h20, 32'd0, lat, ncyc, nstb, nunst, err, rd);
        chk("to_ncyc", 32'(ncyc), 32'd16);
        chk("to_lat",  32'(lat),  32'd17);
        chk("to_err",  32'(err),  32'd1);
        chk("to_data", rd, 32'd0);

        // Normal traffic after a timeout
        mode = 0;
        do_req(1'b1, 2'b00, 6'h21, 32'hFFFF_FFA5, lat, ncyc, nstb, nunst, err, rd);
        chk("post_to_lat", 32'(lat), 32'd2);
        chk("post_to_err", 32'(err), 32'd0);
        do_req(1'b0, 2'b10, 6'h20, 32'd0, lat, ncyc, nstb, nunst, err, rd);
        chk("post_to_rd", rd, 32'h5A5A_A55A);

        // Reserved width: no bus cycle, immediate error response
        do_req(1'b0, 2'b11, 6'h08, 32'd0, lat, ncyc, nstb, nunst, err, rd);
        chk("rsv_lat",  32'(lat),  32'd1);
        chk("rsv_err",  32'(err),  32'd1);
        chk("rsv_ncyc", 32'(ncyc), 32'd0);
        chk("rsv_data", rd, 32'd0);

        // Asynchronous reset while waiting for an ack
        mode = 1;
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_req_width = 2'b10;
        i_req_addr  = 6'h08;
        @(posedge clk);
        #1 i_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ar_wait_cyc", 32'(o_wb_cyc), 32'd1);
        chk("ar_wait_stb", 32'(o_wb_stb), 32'd0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_cyc", 32'(o_wb_cyc),    32'd0);
        chk("ar_stb", 32'(o_wb_stb),    32'd0);
        chk("ar_rsp", 32'(o_rsp_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        mode = 0;
        @(negedge clk);
        chk("ar_ready", 32'(o_req_ready), 32'd1);
        chk("ar_norsp", 32'(o_rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
